// File: rtl/mips_defs.sv
// Shared MIPS decode definitions: opcode constants, field types and the
// "does this opcode read rt" classification used by hazard detection.
package mips_defs;

    typedef logic [5:0] opcode_t;
    typedef logic [4:0] reg_idx_t;

    localparam opcode_t  OP_RTYPE = 6'h00;
    localparam opcode_t  OP_BEQ   = 6'h04;
    localparam opcode_t  OP_BNE   = 6'h05;
    localparam opcode_t  OP_LW    = 6'h23;
    localparam opcode_t  OP_SW    = 6'h2B;

    localparam reg_idx_t REG_ZERO = 5'd0;

    // Decoded view of a 32-bit MIPS instruction word.
    typedef struct packed {
        opcode_t     opcode;
        reg_idx_t    rs;
        reg_idx_t    rt;
        reg_idx_t    rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
    } instr_fields_t;

    // R-type, branches and stores read rt as a source; every other opcode
    // (immediates, loads, jumps) writes rt or ignores it.
    function automatic logic uses_rt(input opcode_t op);
        logic r;
        r = 1'b0;
        case (op)
            OP_RTYPE, OP_BEQ, OP_BNE, OP_SW: r = 1'b1;
            default:                         r = 1'b0;
        endcase
        return r;
    endfunction

    // Split an instruction word into its standard fields.
    function automatic instr_fields_t decode_fields(input logic [31:0] w);
        instr_fields_t f;
        f.opcode = w[31:26];
        f.rs     = w[25:21];
        f.rt     = w[20:16];
        f.rd     = w[15:11];
        f.shamt  = w[10:6];
        f.funct  = w[5:0];
        return f;
    endfunction

endpackage

// File: rtl/if_id_stage_hazard_detect.sv
// Load-use hazard detection for the instruction held in IF/ID.
// A load in EX whose destination is a source of the ID instruction forces
// a one-cycle-at-a-time stall until the load has moved on.
module hazard_detect
    import mips_defs::*;
(
    input  logic     valid_i,
    input  opcode_t  opcode_i,
    input  reg_idx_t rs_i,
    input  reg_idx_t rt_i,
    input  logic     id_ex_mem_read_i,
    input  reg_idx_t id_ex_rt_i,
    output logic     stall_o
);

    logic rs_match;
    logic rt_match;
    logic load_dst_live;

    // Compare the load destination against the ID sources; $0 never hazards.
    always_comb begin
        rs_match      = (id_ex_rt_i == rs_i);
        rt_match      = uses_rt(opcode_i) && (id_ex_rt_i == rt_i);
        load_dst_live = id_ex_mem_read_i && (id_ex_rt_i != REG_ZERO);
        stall_o       = valid_i && load_dst_live && (rs_match || rt_match);
    end

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with load-use hazard detection, decode field
// split and saturating stall/flush performance counters.
// Update priority per edge: rst > stall > flush > load.
module if_id_stage
    import mips_defs::*;
#(
    parameter int unsigned      WIDTH     = 32,
    parameter int unsigned      CNT_WIDTH = 32,
    parameter logic [WIDTH-1:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     pc_plus4_in,
    input  logic [WIDTH-1:0]     instr_in,
    input  logic                 flush,
    input  logic                 id_ex_mem_read,
    input  logic [4:0]           id_ex_rt,
    output logic                 stall,
    output logic [WIDTH-1:0]     pc_plus4_out,
    output logic [WIDTH-1:0]     instr_out,
    output logic                 valid_out,
    output logic [5:0]           opcode,
    output logic [4:0]           rs,
    output logic [4:0]           rt,
    output logic [4:0]           rd,
    output logic [4:0]           shamt,
    output logic [5:0]           funct,
    output logic [15:0]          imm16,
    output logic [CNT_WIDTH-1:0] stall_count,
    output logic [CNT_WIDTH-1:0] flush_count
);

    logic [WIDTH-1:0]     pc_q,        pc_d;
    logic [WIDTH-1:0]     instr_q,     instr_d;
    logic                 valid_q,     valid_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

    instr_fields_t        fields;
    logic                 stall_w;
    logic                 flush_eff;

    // Field split is pure wiring off the held instruction.
    always_comb begin
        fields = decode_fields(instr_q[31:0]);
    end

    hazard_detect u_hazard_detect (
        .valid_i          (valid_q),
        .opcode_i         (fields.opcode),
        .rs_i             (fields.rs),
        .rt_i             (fields.rt),
        .id_ex_mem_read_i (id_ex_mem_read),
        .id_ex_rt_i       (id_ex_rt),
        .stall_o          (stall_w)
    );

    // A branch decision made during a load-use stall is stale, so the
    // stall masks the flush entirely (including its count).
    always_comb begin
        flush_eff = flush && !stall_w;
    end

    // Next-state selection for the pipeline register and counters.
    always_comb begin
        pc_d        = pc_q;
        instr_d     = instr_q;
        valid_d     = valid_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (stall_w) begin
            if (stall_cnt_q != '1) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
        end else if (flush_eff) begin
            pc_d    = pc_plus4_in;
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
            if (flush_cnt_q != '1) begin
                flush_cnt_d = flush_cnt_q + 1'b1;
            end
        end else begin
            pc_d    = pc_plus4_in;
            instr_d = instr_in;
            valid_d = 1'b1;
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= '0;
            instr_q     <= NOP_INSTR;
            valid_q     <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            valid_q     <= valid_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Output mapping.
    always_comb begin
        stall        = stall_w;
        pc_plus4_out = pc_q;
        instr_out    = instr_q;
        valid_out    = valid_q;
        opcode       = fields.opcode;
        rs           = fields.rs;
        rt           = fields.rt;
        rd           = fields.rd;
        shamt        = fields.shamt;
        funct        = fields.funct;
        imm16        = instr_q[15:0];
        stall_count  = stall_cnt_q;
        flush_count  = flush_cnt_q;
    end

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: directed vectors, a cycle model of
// the pipeline register, and literal checks for the documented scenarios.
// A second instance with 4-bit counters exercises saturation.
module tb_if_id_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in;
    logic [31:0] instr_in;
    logic        flush;
    logic        mr;
    logic [4:0]  ert;

    logic        stall, valid_o;
    logic [31:0] pc_o, instr_o;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm16;
    logic [31:0] scnt, fcnt;

    logic        s_stall, s_valid;
    logic [31:0] s_pc, s_instr;
    logic [5:0]  s_opcode, s_funct;
    logic [4:0]  s_rs, s_rt, s_rd, s_shamt;
    logic [15:0] s_imm16;
    logic [3:0]  s_scnt, s_fcnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    if_id_stage #(.WIDTH(32), .CNT_WIDTH(32), .NOP_INSTR(32'h0)) dut (
        .clk(clk), .rst(rst), .pc_plus4_in(pc_in), .instr_in(instr_in),
        .flush(flush), .id_ex_mem_read(mr), .id_ex_rt(ert), .stall(stall),
        .pc_plus4_out(pc_o), .instr_out(instr_o), .valid_out(valid_o),
        .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
        .funct(funct), .imm16(imm16), .stall_count(scnt), .flush_count(fcnt)
    );

    if_id_stage #(.WIDTH(32), .CNT_WIDTH(4), .NOP_INSTR(32'h0)) dut_s (
        .clk(clk), .rst(rst), .pc_plus4_in(pc_in), .instr_in(instr_in),
        .flush(flush), .id_ex_mem_read(mr), .id_ex_rt(ert), .stall(s_stall),
        .pc_plus4_out(s_pc), .instr_out(s_instr), .valid_out(s_valid),
        .opcode(s_opcode), .rs(s_rs), .rt(s_rt), .rd(s_rd), .shamt(s_shamt),
        .funct(s_funct), .imm16(s_imm16), .stall_count(s_scnt), .flush_count(s_fcnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_known = 1'b0;
    logic [31:0] m_pc, m_instr;
    bit          m_valid;
    longint      m_scnt, m_fcnt;

    function automatic bit exp_stall(bit v, logic [31:0] ins, bit mrd, logic [4:0] lrt);
        logic [5:0] op;
        bit reads_rt;
        op = ins[31:26];
        reads_rt = (op == 6'h00) || (op == 6'h04) || (op == 6'h05) || (op == 6'h2B);
        if (!v || !mrd || lrt == 5'd0) return 1'b0;
        return (lrt == ins[25:21]) || (reads_rt && lrt == ins[20:16]);
    endfunction

    function automatic longint sat(longint v, longint maxv);
        return (v >= maxv) ? maxv : v;
    endfunction

    always @(posedge clk) begin
        bit st;
        st = exp_stall(m_valid, m_instr, mr, ert);
        if (rst) begin
            m_known = 1'b1;
            m_pc = 0; m_instr = 0; m_valid = 0; m_scnt = 0; m_fcnt = 0;
        end else if (st) begin
            m_scnt = m_scnt + 1;
        end else if (flush) begin
            m_pc = pc_in; m_instr = 0; m_valid = 0; m_fcnt = m_fcnt + 1;
        end else begin
            m_pc = pc_in; m_instr = instr_in; m_valid = 1;
        end
    end

    // Every-cycle comparison against the model, mid-cycle.
    always @(negedge clk) begin
        if (m_known) begin
            bit st;
            st = exp_stall(m_valid, m_instr, mr, ert);
            chk("m_stall",  stall,    st);
            chk("m_pc",     pc_o,     m_pc);
            chk("m_instr",  instr_o,  m_instr);
            chk("m_valid",  valid_o,  m_valid);
            chk("m_opcode", opcode,   m_instr[31:26]);
            chk("m_rs",     rs,       m_instr[25:21]);
            chk("m_rt",     rt,       m_instr[20:16]);
            chk("m_rd",     rd,       m_instr[15:11]);
            chk("m_shamt",  shamt,    m_instr[10:6]);
            chk("m_funct",  funct,    m_instr[5:0]);
            chk("m_imm16",  imm16,    m_instr[15:0]);
            chk("m_scnt",   scnt,     sat(m_scnt, 64'hFFFF_FFFF));
            chk("m_fcnt",   fcnt,     sat(m_fcnt, 64'hFFFF_FFFF));
            chk("m_s_stall", s_stall, st);
            chk("m_s_scnt", s_scnt,   sat(m_scnt, 15));
            chk("m_s_fcnt", s_fcnt,   sat(m_fcnt, 15));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] ins;
        logic [4:0]  lrt;
        bit          exp;
    } hz_vec_t;

    hz_vec_t hz_tab[6];

    initial begin
        hz_tab[0] = '{32'hAC220000, 5'd2, 1'b1}; // sw reads rt
        hz_tab[1] = '{32'h8C220000, 5'd2, 1'b0}; // lw writes rt
        hz_tab[2] = '{32'h10220003, 5'd2, 1'b1}; // beq reads rt
        hz_tab[3] = '{32'h14220003, 5'd2, 1'b1}; // bne reads rt
        hz_tab[4] = '{32'h8C220000, 5'd1, 1'b1}; // rs always a source
        hz_tab[5] = '{32'h00001020, 5'd0, 1'b0}; // $0 never hazards

        rst = 1'b1; pc_in = '0; instr_in = '0; flush = 1'b0; mr = 1'b0; ert = '0;
        step(); step();
        rst = 1'b0;
        chk("rst_pc", pc_o, 0);
        chk("rst_instr", instr_o, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_stall", stall, 0);
        chk("rst_scnt", scnt, 0);
        chk("rst_fcnt", fcnt, 0);

        // 1. basic load
        instr_in = 32'h2008FFFF; pc_in = 32'd4;
        step();
        chk("t1_opcode", opcode, 6'h08);
        chk("t1_rt", rt, 5'd8);
        chk("t1_imm16", imm16, 16'hFFFF);
        chk("t1_pc", pc_o, 32'd4);
        chk("t1_valid", valid_o, 1);

        // 2. load-use stall
        instr_in = 32'h00221820; pc_in = 32'd8;
        step();
        mr = 1'b1; ert = 5'd1;
        instr_in = 32'hDEADBEEF; pc_in = 32'd12;
        #1;
        chk("t2_stall", stall, 1);
        repeat (3) step();
        chk("t2_instr_frozen", instr_o, 32'h00221820);
        chk("t2_pc_frozen", pc_o, 32'd8);
        chk("t2_scnt", scnt, 3);
        ert = 5'd2; #1;
        chk("t2_rtype_rt", stall, 1);
        ert = 5'd0; #1;
        chk("t2_reg0", stall, 0);
        mr = 1'b0;

        // 3. false hazard on a destination rt
        instr_in = 32'h20C50001; pc_in = 32'd16;
        step();
        mr = 1'b1; ert = 5'd5; #1;
        chk("t3_false_hz", stall, 0);
        ert = 5'd6; #1;
        chk("t3_rs_hz", stall, 1);
        mr = 1'b0;

        // opcode classification table
        foreach (hz_tab[i]) begin
            mr = 1'b0; instr_in = hz_tab[i].ins; pc_in = 32'd100 + 32'(4 * i);
            step();
            mr = 1'b1; ert = hz_tab[i].lrt; #1;
            chk($sformatf("hz_tab%0d", i), stall, hz_tab[i].exp);
        end
        mr = 1'b0; ert = 5'd0;

        // 4. flush, then flush masked by a stall
        flush = 1'b1; pc_in = 32'd200;
        step();
        flush = 1'b0;
        chk("t4_instr", instr_o, 0);
        chk("t4_valid", valid_o, 0);
        chk("t4_pc", pc_o, 32'd200);
        chk("t4_fcnt", fcnt, 1);
        instr_in = 32'h00221820; pc_in = 32'd204;
        step();
        mr = 1'b1; ert = 5'd1; flush = 1'b1; pc_in = 32'd208;
        step();
        chk("t4_hold_instr", instr_o, 32'h00221820);
        chk("t4_hold_valid", valid_o, 1);
        chk("t4_hold_fcnt", fcnt, 1);
        chk("t4_scnt", scnt, 4);

        // 5. reset while stalled and flushing
        chk("t5_pre_stall", stall, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_instr", instr_o, 0);
        chk("t5_valid", valid_o, 0);
        chk("t5_scnt", scnt, 0);
        chk("t5_fcnt", fcnt, 0);
        chk("t5_stall", stall, 0);
        flush = 1'b0;

        // 6. saturation of the 4-bit counters
        mr = 1'b0; instr_in = 32'h00221820; pc_in = 32'd300;
        step();
        mr = 1'b1; ert = 5'd1;
        repeat (20) step();
        chk("t6_sat", s_scnt, 4'd15);
        chk("t6_wide", scnt, 20);
        step();
        chk("t6_sat_hold", s_scnt, 4'd15);
        mr = 1'b0;
        step(); step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
